// File: rtl/dram_pkg.sv
// -----------------------------------------------------------------------------
// dram_pkg
//
// Shared DRAM controller definitions:
//   - default refresh timing constants for a 150 MHz controller clock
//   - refresh scheduler FSM state encoding
//   - DRAM command encodings ({ras_n, cas_n, we_n}) shared with the scheduler
//   - small elaboration-time helper functions
// -----------------------------------------------------------------------------
package dram_pkg;

    // Default timing at 150 MHz (6.67 ns clock).
    localparam int DEF_TRP      = 3;    // precharge period, ~20 ns
    localparam int DEF_TRFC     = 53;   // refresh cycle time, 350 ns
    localparam int DEF_MAX_PEND = 8;    // JEDEC limit on postponed refreshes
    localparam int DEF_PW       = 4;    // width that holds DEF_MAX_PEND

    // Refresh scheduler FSM states.
    typedef enum logic [2:0] {
        RS_IDLE      = 3'd0,
        RS_REQ       = 3'd1,
        RS_PRE       = 3'd2,
        RS_WAIT_TRP  = 3'd3,
        RS_REF       = 3'd4,
        RS_WAIT_TRFC = 3'd5
    } ref_state_t;

    // DRAM command encodings as driven onto {ras_n, cas_n, we_n}.
    typedef enum logic [2:0] {
        CMD_MRS   = 3'b000,
        CMD_REF   = 3'b001,
        CMD_PRE   = 3'b010,
        CMD_ACT   = 3'b011,
        CMD_WR    = 3'b100,
        CMD_RD    = 3'b101,
        CMD_BST   = 3'b110,
        CMD_NOP   = 3'b111
    } dram_cmd_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : dram_pkg

// File: rtl/refresh_timer.sv
// -----------------------------------------------------------------------------
// refresh_timer
//
// Loadable down-counter used by the refresh scheduler for both the tRP and the
// tRFC waits. The counter stops at zero.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset (count -> 0)
//   load      in   load load_val this cycle
//   load_val  in   W  value to load
//   zero      out  wait expires this cycle: the count is 1 (reaches 0 at the
//                  coming edge) or already 0
// -----------------------------------------------------------------------------
module refresh_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    // Flagging the last cycle (count == 1) rather than count == 0 makes a wait
    // state loaded with N last exactly N cycles, so the state after the wait
    // lands N+1 cycles after the load cycle.
    assign zero = (count <= W'(1));

endmodule : refresh_timer

// File: rtl/refresh_scheduler.sv
// -----------------------------------------------------------------------------
// refresh_scheduler
//
// Turns the one-cycle tREFI tick into a legal auto-refresh sequence: counts
// postponed refreshes, requests the command bus, precharges all banks when a
// row is open, issues REFRESH and then holds the bus for tRFC.
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   refresh_flag  in   one-cycle tick, one per tREFI
//   ctrl_idle     in   main scheduler has no queued traffic
//   bank_open     in   at least one bank has an open row (used at grant only)
//   grant         in   command bus granted (only looked at while requesting)
//   ref_req       out  command bus request
//   ref_urgent    out  pending == MAX_PEND
//   ref_busy      out  bus owned; scheduler must not issue commands
//   cmd_pre_all   out  PRECHARGE-ALL strobe
//   cmd_ref       out  REFRESH strobe
//   pending       out  PW  outstanding refresh count
//   overflow      out  sticky: tick lost because pending was saturated
// -----------------------------------------------------------------------------
module refresh_scheduler
    import dram_pkg::*;
#(
    parameter int TRP      = DEF_TRP,
    parameter int TRFC     = DEF_TRFC,
    parameter int MAX_PEND = DEF_MAX_PEND,
    parameter int PW       = DEF_PW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          refresh_flag,
    input  logic          ctrl_idle,
    input  logic          bank_open,
    input  logic          grant,
    output logic          ref_req,
    output logic          ref_urgent,
    output logic          ref_busy,
    output logic          cmd_pre_all,
    output logic          cmd_ref,
    output logic [PW-1:0] pending,
    output logic          overflow
);

    localparam int TW = $clog2(max_int(TRP, TRFC));

    localparam logic [PW-1:0] MAX_P = PW'(MAX_PEND);

    localparam logic [2:0] IDLE      = RS_IDLE;
    localparam logic [2:0] REQ       = RS_REQ;
    localparam logic [2:0] PRE       = RS_PRE;
    localparam logic [2:0] WAIT_TRP  = RS_WAIT_TRP;
    localparam logic [2:0] REF       = RS_REF;
    localparam logic [2:0] WAIT_TRFC = RS_WAIT_TRFC;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [PW-1:0] pending_nxt;
    logic          ovf_set;
    logic          ref_dec;
    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          timer_zero;

    // ------------------------------------------------------------------
    // Pending refresh counter
    // ------------------------------------------------------------------
    assign ref_dec = (state == REF);

    always_comb begin
        pending_nxt = pending;
        ovf_set     = 1'b0;
        if (refresh_flag && !ref_dec) begin
            if (pending == MAX_P) begin
                ovf_set = 1'b1;
            end else begin
                pending_nxt = pending + PW'(1);
            end
        end else if (!refresh_flag && ref_dec) begin
            pending_nxt = pending - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (ovf_set) begin
                overflow <= 1'b1;
            end
        end
    end

    assign ref_urgent = (pending == MAX_P);

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        timer_load = 1'b0;
        timer_val  = '0;
        unique case (state)
            IDLE: begin
                // Look at the count as it will be after this edge so a tick
                // raises the request in the very next cycle.
                if ((pending_nxt != '0) && (ctrl_idle || (pending_nxt == MAX_P))) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (grant) begin
                    state_nxt = bank_open ? PRE : REF;
                end
            end
            PRE: begin
                timer_load = 1'b1;
                timer_val  = TW'(TRP - 1);
                state_nxt  = WAIT_TRP;
            end
            WAIT_TRP: begin
                if (timer_zero) begin
                    state_nxt = REF;
                end
            end
            REF: begin
                timer_load = 1'b1;
                timer_val  = TW'(TRFC - 1);
                state_nxt  = WAIT_TRFC;
            end
            WAIT_TRFC: begin
                if (timer_zero) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    refresh_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    // Outputs decode straight from the state register, so reset forces them
    // low in the cycle after rst and strobes are inherently one state wide.
    assign ref_req     = (state == REQ);
    assign cmd_pre_all = (state == PRE);
    assign cmd_ref     = (state == REF);
    assign ref_busy    = (state == PRE) || (state == WAIT_TRP) ||
                         (state == REF) || (state == WAIT_TRFC);

endmodule : refresh_scheduler

// File: tb/tb_refresh_scheduler.sv
module tb_refresh_scheduler;

    localparam int TRP      = 3;
    localparam int TRFC     = 53;
    localparam int MAX_PEND = 8;
    localparam int PW       = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          refresh_flag;
    logic          ctrl_idle;
    logic          bank_open;
    logic          grant;
    logic          ref_req;
    logic          ref_urgent;
    logic          ref_busy;
    logic          cmd_pre_all;
    logic          cmd_ref;
    logic [PW-1:0] pending;
    logic          overflow;

    always #5 clk = ~clk;

    refresh_scheduler #(
        .TRP      (TRP),
        .TRFC     (TRFC),
        .MAX_PEND (MAX_PEND),
        .PW       (PW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .refresh_flag (refresh_flag),
        .ctrl_idle    (ctrl_idle),
        .bank_open    (bank_open),
        .grant        (grant),
        .ref_req      (ref_req),
        .ref_urgent   (ref_urgent),
        .ref_busy     (ref_busy),
        .cmd_pre_all  (cmd_pre_all),
        .cmd_ref      (cmd_ref),
        .pending      (pending),
        .overflow     (overflow)
    );

    // Expected per-cycle levels, and expected command strobes.
    typedef struct packed {
        int            cyc;
        logic          req;
        logic          urg;
        logic          busy;
        logic          pre;
        logic          rf;
        logic          ovf;
        logic [PW-1:0] pend;
    } lvl_t;

    typedef struct packed {
        int   cyc;
        logic is_ref;
    } evt_t;

    lvl_t lvl_q[$];
    evt_t evt_q[$];
    int   ref_seen[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Behavioural reference: a bus-request phase, then a busy window described
    // by absolute cycle numbers of the PRE and REF commands.
    typedef enum int {M_IDLE, M_REQ, M_BUSY} mmode_t;
    mmode_t m_mode    = M_IDLE;
    int     m_pend    = 0;
    bit     m_ovf     = 1'b0;
    int     m_pre_at  = -1;
    int     m_ref_at  = -1;
    int     m_req_age = 0;

    task automatic push_levels();
        lvl_t e;
        e.cyc  = cyc;
        e.req  = (m_mode == M_REQ);
        e.urg  = (m_pend == MAX_PEND);
        e.busy = (m_mode == M_BUSY);
        e.pre  = (m_mode == M_BUSY) && (cyc == m_pre_at);
        e.rf   = (m_mode == M_BUSY) && (cyc == m_ref_at);
        e.ovf  = m_ovf;
        e.pend = PW'(m_pend);
        lvl_q.push_back(e);
    endtask

    task automatic model_step(input bit r, input bit f, input bit ci, input bit bo, input bit g);
        bit   dec;
        int   np;
        evt_t ev;
        if (r) begin
            m_mode    = M_IDLE;
            m_pend    = 0;
            m_ovf     = 1'b0;
            m_req_age = 0;
            m_pre_at  = -1;
            m_ref_at  = -1;
            for (int i = evt_q.size() - 1; i >= 0; i--) begin
                if (evt_q[i].cyc > cyc) evt_q.delete(i);
            end
            return;
        end
        dec = (m_mode == M_BUSY) && (cyc == m_ref_at);
        np  = m_pend + (f ? 1 : 0) - (dec ? 1 : 0);
        if (np > MAX_PEND) begin
            np    = MAX_PEND;
            m_ovf = 1'b1;
        end
        case (m_mode)
            M_IDLE: begin
                if (np > 0 && (ci || np == MAX_PEND)) begin
                    m_mode    = M_REQ;
                    m_req_age = 0;
                end
            end
            M_REQ: begin
                if (g) begin
                    m_mode = M_BUSY;
                    if (bo) begin
                        m_pre_at  = cyc + 1;
                        m_ref_at  = cyc + 1 + TRP;
                        ev.cyc    = m_pre_at;
                        ev.is_ref = 1'b0;
                        evt_q.push_back(ev);
                    end else begin
                        m_pre_at = -1;
                        m_ref_at = cyc + 1;
                    end
                    ev.cyc    = m_ref_at;
                    ev.is_ref = 1'b1;
                    evt_q.push_back(ev);
                end else begin
                    m_req_age++;
                end
            end
            default: begin
                if (cyc == m_ref_at + TRFC - 1) m_mode = M_IDLE;
            end
        endcase
        m_pend = np;
    endtask

    task automatic step(input bit r, input bit f, input bit ci, input bit bo, input bit g);
        push_levels();
        rst          = r;
        refresh_flag = f;
        ctrl_idle    = ci;
        bank_open    = bo;
        grant        = g;
        model_step(r, f, ci, bo, g);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // bo_mode: 0 low, 1 high, 2 random. g_mode: 0 never, 1 always,
    // 2 one cycle after the request appears, 3 random (also outside REQ).
    task automatic auto(input bit r, input bit f, input bit ci, input int bo_mode, input int g_mode);
        bit bo;
        bit g;
        bo = (bo_mode == 2) ? 1'($urandom % 2) : (bo_mode == 1);
        case (g_mode)
            1:       g = 1'b1;
            2:       g = (m_mode == M_REQ) && (m_req_age >= 1);
            3:       g = ($urandom % 4 == 0);
            default: g = 1'b0;
        endcase
        step(r, f, ci, bo, g);
    endtask

    // Monitor: compares levels every cycle and pops the strobe scoreboard
    // whenever the DUT emits a command.
    lvl_t          mon_e;
    evt_t          mon_ev;
    logic [10:0]   mon_act;
    logic [10:0]   mon_exp;

    initial begin
        forever begin
            @(negedge clk);
            if (lvl_q.size() > 0) begin
                mon_e   = lvl_q.pop_front();
                mon_act = {ref_req, ref_urgent, ref_busy, cmd_pre_all, cmd_ref, overflow, pending};
                mon_exp = {mon_e.req, mon_e.urg, mon_e.busy, mon_e.pre, mon_e.rf, mon_e.ovf, mon_e.pend};
                checks++;
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL levels cyc %0d req,urg,busy,pre,ref,ovf,pend got %b want %b",
                             mon_e.cyc, mon_act, mon_exp);
                end
            end
            if (cmd_pre_all === 1'b1) begin
                checks++;
                if (evt_q.size() == 0) begin
                    errors++;
                    $display("FAIL pre_strobe cyc %0d got PRE want no command", cyc);
                end else begin
                    mon_ev = evt_q.pop_front();
                    if (mon_ev.cyc != cyc || mon_ev.is_ref != 1'b0) begin
                        errors++;
                        $display("FAIL pre_strobe got PRE at cyc %0d want %s at cyc %0d",
                                 cyc, mon_ev.is_ref ? "REF" : "PRE", mon_ev.cyc);
                    end
                end
            end
            if (cmd_ref === 1'b1) begin
                ref_seen.push_back(cyc);
                checks++;
                if (evt_q.size() == 0) begin
                    errors++;
                    $display("FAIL ref_strobe cyc %0d got REF want no command", cyc);
                end else begin
                    mon_ev = evt_q.pop_front();
                    if (mon_ev.cyc != cyc || mon_ev.is_ref != 1'b1) begin
                        errors++;
                        $display("FAIL ref_strobe got REF at cyc %0d want %s at cyc %0d",
                                 cyc, mon_ev.is_ref ? "REF" : "PRE", mon_ev.cyc);
                    end
                end
            end
        end
    end

    initial begin
        bit done;
        bit f;
        rst          = 1'b1;
        refresh_flag = 1'($urandom % 2);
        ctrl_idle    = 1'($urandom % 2);
        bank_open    = 1'($urandom % 2);
        grant        = 1'($urandom % 2);
        @(posedge clk);
        #1;

        // Reset held with random inputs.
        for (int i = 0; i < 2; i++) auto(1'b1, 1'($urandom % 2), 1'($urandom % 2), 2, 3);
        for (int i = 0; i < 3; i++) auto(1'b0, 1'b0, 1'b1, 0, 2);

        // Single tick, no open row.
        auto(1'b0, 1'b1, 1'b1, 0, 2);
        for (int i = 0; i < 60; i++) auto(1'b0, 1'b0, 1'b1, 0, 2);

        // Single tick, open row: PRE-ALL then REF after tRP.
        auto(1'b0, 1'b1, 1'b1, 1, 2);
        for (int i = 0; i < 64; i++) auto(1'b0, 1'b0, 1'b1, 1, 2);

        // Postponement then back-to-back drain with grant tied high.
        for (int i = 0; i < 4; i++) begin
            auto(1'b0, 1'b1, 1'b0, 2, 0);
            auto(1'b0, 1'b0, 1'b0, 2, 0);
            auto(1'b0, 1'b0, 1'b0, 2, 0);
        end
        ref_seen.delete();
        for (int i = 0; i < 4 * (TRFC + 2) + 10; i++) auto(1'b0, 1'b0, 1'b1, 0, 1);
        checks++;
        if (ref_seen.size() != 4) begin
            errors++;
            $display("FAIL drain_count got %0d REF strobes want 4", ref_seen.size());
        end
        for (int i = 1; i < ref_seen.size(); i++) begin
            checks++;
            if (ref_seen[i] - ref_seen[i-1] != TRFC + 2) begin
                errors++;
                $display("FAIL drain_spacing got %0d cycles want %0d",
                         ref_seen[i] - ref_seen[i-1], TRFC + 2);
            end
        end

        // Saturation and sticky overflow.
        auto(1'b1, 1'b0, 1'b0, 2, 0);
        for (int i = 0; i < 9; i++) begin
            auto(1'b0, 1'b1, 1'b0, 2, 0);
            auto(1'b0, 1'b0, 1'b0, 2, 0);
        end
        for (int i = 0; i < 6; i++) auto(1'b0, 1'($urandom % 2), 1'b0, 2, 0);
        auto(1'b1, 1'b0, 1'b0, 2, 0);
        for (int i = 0; i < 3; i++) auto(1'b0, 1'b0, 1'b0, 2, 0);

        // Tick coincident with REF at pending 3, then reset inside tRFC.
        for (int i = 0; i < 3; i++) auto(1'b0, 1'b1, 1'b0, 0, 0);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            f = (m_mode == M_BUSY) && (cyc == m_ref_at);
            if (f) done = 1'b1;
            auto(1'b0, f, 1'b1, 0, 2);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL coincident_tick got no REF window within 20 cycles want one");
        end
        for (int i = 0; i < 10; i++) auto(1'b0, 1'b0, 1'b0, 0, 0);
        auto(1'b1, 1'b0, 1'b0, 2, 3);
        for (int i = 0; i < 5; i++) auto(1'b0, 1'b0, 1'b0, 2, 3);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            auto(1'($urandom % 500 == 0), 1'($urandom % 12 == 0), 1'($urandom % 3 != 0), 2,
                 ($urandom % 2 == 0) ? 3 : 2);
        end

        // Drain: no new grants, let any busy window finish.
        for (int i = 0; i < TRFC + TRP + 10; i++) auto(1'b0, 1'b0, 1'b0, 2, 0);
        @(negedge clk);
        checks++;
        if (evt_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_strobes got %0d outstanding want 0", evt_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_refresh_scheduler
